// File: rtl/shift_step_ctrl.sv
// Step sequencer around an external 8-bit combinational shifter: splits a signed shift into <=2-bit steps.
// Optional build macro SHIFT_STAT_EN adds a saturating completed-operation counter (stat_ops).
module shift_step_ctrl #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:WIDTH-1]        in_data,
  input  logic signed [AMT_W-1:0] in_amt,
  output logic [0:WIDTH-1]        sh_ip,
  output logic [4:0]              sh_mag,
  input  logic [0:WIDTH-1]        sh_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [0:WIDTH-1]        out_data,
  output logic                    busy
`ifdef SHIFT_STAT_EN
  ,
  output logic [15:0]             stat_ops
`endif
);

  localparam logic [4:0] MAG_NONE = 5'b00100;
  localparam logic [4:0] MAG_L1   = 5'b00010;
  localparam logic [4:0] MAG_L2   = 5'b00001;
  localparam logic [4:0] MAG_R1   = 5'b01000;
  localparam logic [4:0] MAG_R2   = 5'b10000;

  localparam logic signed [AMT_W-1:0] REM_ZERO = {AMT_W{1'b0}};
  localparam logic signed [AMT_W-1:0] REM_ONE  = AMT_W'(1);
  localparam logic signed [AMT_W-1:0] REM_TWO  = AMT_W'(2);
  localparam logic signed [AMT_W-1:0] REM_MONE = {AMT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                    state_q;
  logic [0:WIDTH-1]          work_q;
  logic signed [AMT_W-1:0]   rem_q;
  logic [4:0]                sh_mag_q;
  logic                      out_valid_q;
  logic                      busy_q;
  logic                      in_ready_q;

  logic signed [AMT_W-1:0]   step_s;
  logic signed [AMT_W-1:0]   rem_d;
  logic                      accept_s;

  // Shifter code for the next step; the most-negative amount falls into the R2 branch with no special case.
  function automatic logic [4:0] mag_code(input logic signed [AMT_W-1:0] r);
    logic [4:0] m;
    if (r == REM_ZERO) begin
      m = MAG_NONE;
    end else if (r == REM_ONE) begin
      m = MAG_L1;
    end else if (r == REM_MONE) begin
      m = MAG_R1;
    end else if (r > REM_ZERO) begin
      m = MAG_L2;
    end else begin
      m = MAG_R2;
    end
    return m;
  endfunction

  assign accept_s = in_valid && in_ready_q;

  // Remaining-shift update for the step in progress.
  always_comb begin
    step_s = REM_TWO;
    rem_d  = rem_q;
    if ((rem_q == REM_ONE) || (rem_q == REM_MONE)) begin
      step_s = REM_ONE;
    end else begin
      step_s = REM_TWO;
    end
    if (rem_q > REM_ZERO) begin
      rem_d = rem_q - step_s;
    end else begin
      rem_d = rem_q + step_s;
    end
  end

  // Control FSM; every output is a register so the shifter and consumer see glitch-free values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      work_q      <= {WIDTH{1'b0}};
      rem_q       <= REM_ZERO;
      sh_mag_q    <= MAG_NONE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            work_q     <= in_data;
            rem_q      <= in_amt;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            if (in_amt != REM_ZERO) begin
              state_q  <= S_STEP;
              sh_mag_q <= mag_code(in_amt);
            end else begin
              state_q     <= S_DONE;
              sh_mag_q    <= MAG_NONE;
              out_valid_q <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_STEP: begin
          work_q   <= sh_op;
          rem_q    <= rem_d;
          sh_mag_q <= mag_code(rem_d);
          if (rem_d == REM_ZERO) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end else begin
            state_q <= S_STEP;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end else begin
            state_q <= S_DONE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          work_q      <= {WIDTH{1'b0}};
          rem_q       <= REM_ZERO;
          sh_mag_q    <= MAG_NONE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign sh_ip     = work_q;
  assign sh_mag    = sh_mag_q;
  assign out_data  = work_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign in_ready  = in_ready_q;

`ifdef SHIFT_STAT_EN
  logic [15:0] stat_ops_q;

  // Completed-operation counter, saturating so it never wraps back to a misleading small value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q <= 16'h0000;
    end else if ((state_q == S_DONE) && out_ready && (stat_ops_q != 16'hFFFF)) begin
      stat_ops_q <= stat_ops_q + 16'h0001;
    end else begin
      stat_ops_q <= stat_ops_q;
    end
  end

  assign stat_ops = stat_ops_q;
`endif

endmodule

// File: tb/tb_shift_step_ctrl.sv
// Scoreboard bench for shift_step_ctrl: driver pushes expected results, a monitor pops and compares.
// The external shifter is modelled combinationally here.
module tb_shift_step_ctrl;

  localparam logic [4:0] M_NONE = 5'b00100;
  localparam logic [4:0] M_L1   = 5'b00010;
  localparam logic [4:0] M_L2   = 5'b00001;
  localparam logic [4:0] M_R1   = 5'b01000;
  localparam logic [4:0] M_R2   = 5'b10000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [0:7]        in_data = 8'h00;
  logic signed [3:0] in_amt = 4'sd0;
  logic [0:7]        sh_ip;
  logic [4:0]        sh_mag;
  logic [0:7]        sh_op;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [0:7]        out_data;
  logic              busy;
`ifdef SHIFT_STAT_EN
  logic [15:0]       stat_ops;
`endif

  shift_step_ctrl #(.WIDTH(8), .AMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
    .sh_ip(sh_ip), .sh_mag(sh_mag), .sh_op(sh_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef SHIFT_STAT_EN
    , .stat_ops(stat_ops)
`endif
  );

  always #5 clk = ~clk;

  // External shifter: bit 0 is MSB, so << moves toward bit 0.
  always_comb begin
    case (sh_mag)
      M_NONE:  sh_op = sh_ip;
      M_L1:    sh_op = sh_ip << 1;
      M_L2:    sh_op = sh_ip << 2;
      M_R1:    sh_op = sh_ip >> 1;
      M_R2:    sh_op = sh_ip >> 2;
      default: sh_op = ~sh_ip;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [0:7]  data;
    int          acc;
    int          lat;
    logic [19:0] seq;
    int          nsteps;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   hs_cnt = 0;
  int   last_hs_cyc = -10;
  bit   force_stall = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_sh_ip"}, 32'(sh_ip), 32'd0);
    chk({tag, "_sh_mag"}, 32'(sh_mag), 32'(M_NONE));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef SHIFT_STAT_EN
    chk({tag, "_stat_ops"}, 32'(stat_ops), 32'd0);
`endif
  endtask

  // Reference: whole shift at once, step plan as greedy 2-bit chunks.
  function automatic exp_t model(input logic [0:7] d, input logic signed [3:0] a, input int acc);
    exp_t e;
    int ai = a;
    int n  = (ai < 0) ? -ai : ai;
    int n0 = n;
    e.data   = (ai >= 0) ? (d << ai) : (d >> (-ai));
    e.acc    = acc;
    e.lat    = (n0 + 1) / 2 + 1;
    e.seq    = 20'd0;
    e.nsteps = 0;
    while (n > 0) begin
      if (n >= 2) begin
        e.seq = {e.seq[14:0], (ai > 0) ? M_L2 : M_R2};
        n = n - 2;
      end else begin
        e.seq = {e.seq[14:0], (ai > 0) ? M_L1 : M_R1};
        n = n - 1;
      end
      e.nsteps++;
    end
    return e;
  endfunction

  task automatic send(input logic [0:7] d, input logic signed [3:0] a);
    bit waited = 1'b0;
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    while (!in_ready && n < 100) begin
      waited = 1'b1;
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      sb_q.push_back(model(d, a, cyc));
      if (waited) chk("bubble_accept_cycle", 32'(cyc), 32'(last_hs_cyc + 1));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_amt   = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      out_ready = force_stall ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops one expectation per result and checks hold/stability rules every cycle.
  initial begin
    bit          in_txn = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_hs = 1'b0;
    logic [19:0] rec_seq = 20'd0;
    int          rec_n = 0;
    logic [0:7]  held = 8'h00;
    exp_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        in_txn = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0;
        rec_seq = 20'd0; rec_n = 0; hs_cnt = 0;
      end else begin
        chk("in_ready_vs_busy", 32'(in_ready), 32'(!busy));
        if (sh_mag != M_NONE) begin
          rec_seq = {rec_seq[14:0], sh_mag};
          rec_n++;
          chk("busy_in_step", 32'(busy), 32'd1);
        end
        if (prev_valid && !prev_hs) chk("out_valid_hold", 32'(out_valid), 32'd1);
        if (out_valid) begin
          chk("busy_in_done", 32'(busy), 32'd1);
          if (!in_txn) begin
            chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
              e = sb_q.pop_front();
              chk("out_data", 32'(out_data), 32'(e.data));
              chk("latency", 32'(cyc - e.acc), 32'(e.lat));
              chk("step_count", 32'(rec_n), 32'(e.nsteps));
              chk("mag_seq", 32'(rec_seq), 32'(e.seq));
            end
            held = out_data;
            in_txn = 1'b1;
            rec_seq = 20'd0;
            rec_n = 0;
          end else begin
            chk("out_data_hold", 32'(out_data), 32'(held));
          end
        end
        prev_valid = out_valid;
        prev_hs = out_valid && out_ready;
        if (out_valid && out_ready) begin
          in_txn = 1'b0;
          hs_cnt++;
          last_hs_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send(8'b1010_1101, 4'sd2);
    send(8'b1010_1101, -4'sd3);
    send(8'b0000_0001, 4'sd0);
    send(8'b1111_1111, -4'sd8);

    // Held backpressure while the next request waits with in_valid high.
    send(8'h5A, 4'sd1);
    force_stall = 1'b1;
    fork
      send(8'h3C, -4'sd2);
      begin
        int n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        repeat (5) @(negedge clk);
        #1 force_stall = 1'b0;
      end
    join

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      send(8'($urandom), 4'($urandom));
    end

    // Asynchronous reset in the middle of a +7 stepping sequence.
    drain();
    send(8'h81, 4'sd7);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("midstep_reset");
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 4'($urandom));
    end
    drain();
    repeat (3) @(negedge clk);
`ifdef SHIFT_STAT_EN
    chk("stat_ops", 32'(stat_ops), 32'(hs_cnt));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
